demux_event_counter_8: RTL and testbench
========================================

# demux_event_counter_8

Per-channel event counter bank that sits directly downstream of the 1x8 demultiplexer. Takes the eight demux outputs as a bus, detects rising edges on each line, and keeps one saturating counter per channel. Also flags one-hot violations. A four-phase request/acknowledge port lets a host read any channel's count as a stable snapshot.

## Interface
- CNT_W, default 8: width of each channel counter and of rd_data (legal range 2..16).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- y  input  8  demux outputs; y[k] is demux output yk; synchronous to clk.
- clr  input  1  synchronous clear of all counters, ovf and onehot_err.
- rd_req  input  1  read request, four-phase level handshake.
- rd_sel  input  3  channel to read; sampled when a request is accepted.
- rd_ack  output  1  read acknowledge; rd_data valid while high.
- rd_data  output  CNT_W  snapshot of the selected counter.
- ovf  output  8  sticky per-channel saturation flag.
- onehot_err  output  1  sticky flag: more than one y bit high in a cycle.

## Operation
- Register y into y_q every cycle. rise[k] = y[k] & ~y_q[k].
- Counter k:
  - On rise[k], increments by 1 if cnt[k] < 2^CNT_W-1.
  - At max, it holds and sets ovf[k]. ovf[k] stays set until clr or reset.
- A level held high counts once. Back-to-back pulses count only if separated by at least one low cycle.
- onehot_err is set in any cycle where popcount(y) > 1. The multiple rises in that cycle are still counted individually.
- clr has priority over rise in the same cycle: counters become 0, not 1. ovf and onehot_err also clear. y_q still updates, so a level high across clr does not recount.
- Read FSM, states IDLE, SNAP, ACK:
  - IDLE: if rd_req=1, latch rd_sel into sel_q and go to SNAP.
  - SNAP: load rd_data from cnt[sel_q] and go to ACK.
  - ACK: rd_ack=1. Stay while rd_req=1. When rd_req=0, go to IDLE; rd_ack drops on that edge.
- rd_data holds its value between reads. It changes only on SNAP.
- rd_sel changes after acceptance are ignored until the next IDLE acceptance.
- Snapshot timing: SNAP returns the counter value before any increment or clr occurring in the same cycle.
- clr during SNAP or ACK does not abort the handshake. The read completes with the value as defined above.
- rd_req deasserted during SNAP: the FSM still enters ACK, then returns to IDLE on the next edge because rd_req=0. This gives a one-cycle rd_ack pulse.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - cnt[*]=0, y_q=0, ovf=0, onehot_err=0.
  - rd_data=0, rd_ack=0, state=IDLE.
- Reset mid-handshake aborts the read immediately; rd_ack goes low asynchronously.
- Count latency: y[k] rises before edge N, so cnt[k] updates at edge N. The value is visible to a SNAP in cycle N+1.
- Read latency: rd_req high at edge N (accept). SNAP at edge N+1, where rd_data and state ACK are registered. rd_ack is high after edge N+1, i.e. 2 cycles after the request is sampled.
- rd_ack is driven from state only and is glitch-free. rd_data is registered.
- Minimum read cycle: 4 edges (accept, snap, observe rd_req low, IDLE re-accept possible on the next edge).
- Since y_q resets to 0, a y bit already high when rst_n releases counts once on the first edge.

## Test plan
- Reset, then pulse y=8'b0000_0100 for 1 cycle, 3 times, each separated by 1 low cycle; read rd_sel=2 -> rd_ack rises 2 cycles after rd_req, rd_data=3; all other channels read 0.
- Hold y=8'b1000_0000 high for 10 cycles, then read rd_sel=7 -> rd_data=1, ovf=0.
- CNT_W=2: 4 single-cycle pulses on y[0] -> rd_data=3, ovf=8'b0000_0001; a 5th pulse keeps rd_data=3.
- Drive y=8'b0001_0010 for one cycle -> onehot_err=1, cnt[1]=1, cnt[4]=1; assert clr for one cycle -> onehot_err=0 and both counters read 0.
- Rise on y[5] in the same cycle as SNAP for rd_sel=5 with cnt[5]=4 -> rd_data=4; the next read returns 5. Rise coincident with clr -> the following read returns 0.
- Deassert rst_n while in ACK with rd_data=6 -> rd_ack=0 and rd_data=0 immediately; after release, a read of any channel returns 0.

Source files
------------

// File: rtl/demux_event_counter_8.sv
// Event counter bank behind a 1x8 demux: per-line rising-edge counters that saturate,
// a sticky one-hot violation flag, and a four-phase read port that returns a stable snapshot.
module demux_event_counter_8 #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       y_i,
  input  logic             clr_i,
  input  logic             rd_req_i,
  input  logic [2:0]       rd_sel_i,
  output logic             rd_ack_o,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [7:0]       ovf_o,
  output logic             onehot_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       y_q;
  logic [7:0]       rise;
  logic [7:0]       ovf_q, ovf_d;
  logic             onehot_err_q, onehot_err_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  assign rise = y_i & ~y_q;

  // x & (x-1) is non-zero exactly when more than one bit of x is set
  always_comb begin
    onehot_err_d = onehot_err_q | (|(y_i & (y_i - 8'd1)));
    ovf_d        = ovf_q;
    for (int k = 0; k < 8; k++) begin
      cnt_d[k] = cnt_q[k];
      if (rise[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          ovf_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_ONE;
        end
      end
    end
    if (clr_i) begin
      onehot_err_d = 1'b0;
      ovf_d        = '0;
      for (int k = 0; k < 8; k++) begin
        cnt_d[k] = '0;
      end
    end
  end

  // Snapshot reads cnt_q, so it sees the value before this cycle's increment or clear
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (rd_req_i) begin
          sel_d   = rd_sel_i;
          state_d = SNAP;
        end
      end
      SNAP: begin
        rd_data_d = cnt_q[sel_q];
        state_d   = ACK;
      end
      ACK: begin
        if (!rd_req_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      y_q          <= '0;
      ovf_q        <= '0;
      onehot_err_q <= 1'b0;
      sel_q        <= '0;
      rd_data_q    <= '0;
      for (int k = 0; k < 8; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      y_q          <= y_i;
      ovf_q        <= ovf_d;
      onehot_err_q <= onehot_err_d;
      sel_q        <= sel_d;
      rd_data_q    <= rd_data_d;
      for (int k = 0; k < 8; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign rd_ack_o     = (state_q == ACK);
  assign rd_data_o    = rd_data_q;
  assign ovf_o        = ovf_q;
  assign onehot_err_o = onehot_err_q;

endmodule

// File: tb/tb_demux_event_counter_8.sv
// Scoreboard bench: read tasks queue the expected snapshot, monitors compare on each rd_ack rise.
// Two instances: default CNT_W=8 (a) and CNT_W=2 (b) for saturation.
module tb_demux_event_counter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] y_a, y_b;
  logic       clr_a, clr_b;
  logic       req_a, req_b;
  logic [2:0] sel_a, sel_b;
  logic       ack_a, ack_b;
  logic [7:0] data_a;
  logic [1:0] data_b;
  logic [7:0] ovf_a, ovf_b;
  logic       oh_a, oh_b;

  int tests = 0;
  int fails = 0;
  int qa[$];
  int qb[$];
  logic ack_a_prev = 1'b0;
  logic ack_b_prev = 1'b0;

  always #5 clk = ~clk;

  demux_event_counter_8 #(.CNT_W(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .y_i(y_a), .clr_i(clr_a), .rd_req_i(req_a),
    .rd_sel_i(sel_a), .rd_ack_o(ack_a), .rd_data_o(data_a), .ovf_o(ovf_a),
    .onehot_err_o(oh_a)
  );

  demux_event_counter_8 #(.CNT_W(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .y_i(y_b), .clr_i(clr_b), .rd_req_i(req_b),
    .rd_sel_i(sel_b), .rd_ack_o(ack_b), .rd_data_o(data_b), .ovf_o(ovf_b),
    .onehot_err_o(oh_b)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack_a && !ack_a_prev) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_a: unexpected rd_ack, rd_data=%0d", data_a);
      end else begin
        check("mon_a rd_data", int'(data_a), qa.pop_front());
      end
    end
    ack_a_prev = ack_a;
  end

  always @(negedge clk) begin
    if (ack_b && !ack_b_prev) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_b: unexpected rd_ack, rd_data=%0d", data_b);
      end else begin
        check("mon_b rd_data", int'(data_b), qb.pop_front());
      end
    end
    ack_b_prev = ack_b;
  end

  task automatic pulse(input bit on_b, input logic [7:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (on_b) y_b = mask; else y_a = mask;
      @(negedge clk);
      if (on_b) y_b = '0; else y_a = '0;
    end
  endtask

  // Full handshake; optionally drop rd_req during SNAP or raise y[5] in the SNAP cycle.
  task automatic do_read(input bit on_b, input logic [2:0] sel, input int exp,
                         input bit early_drop, input bit y5_on_snap);
    if (on_b) qb.push_back(exp); else qa.push_back(exp);
    @(negedge clk);
    if (on_b) begin req_b = 1'b1; sel_b = sel; end
    else begin req_a = 1'b1; sel_a = sel; end
    @(posedge clk);
    #1 check("ack low after accept", on_b ? int'(ack_b) : int'(ack_a), 0);
    @(negedge clk);
    if (on_b) sel_b = ~sel; else sel_a = ~sel;
    if (early_drop) begin
      if (on_b) req_b = 1'b0; else req_a = 1'b0;
    end
    if (y5_on_snap) y_a[5] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ack high 2 cycles after req", on_b ? int'(ack_b) : int'(ack_a), 1);
    if (y5_on_snap) y_a[5] = 1'b0;
    if (on_b) req_b = 1'b0; else req_a = 1'b0;
    @(posedge clk);
    #1 check("ack drop after req low", on_b ? int'(ack_b) : int'(ack_a), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    y_a = '0; y_b = '0; clr_a = 1'b0; clr_b = 1'b0;
    req_a = 1'b0; req_b = 1'b0; sel_a = '0; sel_b = '0;
    repeat (3) @(negedge clk);
    check("reset rd_ack", int'(ack_a), 0);
    check("reset rd_data", int'(data_a), 0);
    check("reset ovf", int'(ovf_a), 0);
    check("reset onehot_err", int'(oh_a), 0);
    rst_n = 1'b1;

    // Three separated pulses on y[2]
    pulse(1'b0, 8'b0000_0100, 3);
    do_read(1'b0, 3'd2, 3, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      if (c != 2) do_read(1'b0, 3'(c), 0, 1'b0, 1'b0);
    end

    // Level held high counts once
    @(negedge clk);
    y_a = 8'b1000_0000;
    repeat (10) @(negedge clk);
    y_a = '0;
    do_read(1'b0, 3'd7, 1, 1'b0, 1'b0);
    check("ovf after held level", int'(ovf_a), 0);

    // rd_req dropped during SNAP still yields a one-cycle ack
    do_read(1'b0, 3'd2, 3, 1'b1, 1'b0);

    // Two bits high in one cycle
    @(negedge clk);
    y_a = 8'b0001_0010;
    @(negedge clk);
    y_a = '0;
    check("onehot_err set", int'(oh_a), 1);
    do_read(1'b0, 3'd1, 1, 1'b0, 1'b0);
    do_read(1'b0, 3'd4, 1, 1'b0, 1'b0);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("onehot_err cleared", int'(oh_a), 0);
    do_read(1'b0, 3'd1, 0, 1'b0, 1'b0);
    do_read(1'b0, 3'd4, 0, 1'b0, 1'b0);

    // Snapshot returns pre-increment value; clr beats a coincident rise
    pulse(1'b0, 8'b0010_0000, 4);
    do_read(1'b0, 3'd5, 4, 1'b0, 1'b1);
    do_read(1'b0, 3'd5, 5, 1'b0, 1'b0);
    @(negedge clk);
    y_a = 8'b0010_0000;
    clr_a = 1'b1;
    @(negedge clk);
    y_a = '0;
    clr_a = 1'b0;
    do_read(1'b0, 3'd5, 0, 1'b0, 1'b0);

    // CNT_W=2 saturation
    pulse(1'b1, 8'b0000_0001, 4);
    do_read(1'b1, 3'd0, 3, 1'b0, 1'b0);
    check("b ovf after 4 pulses", int'(ovf_b), 1);
    pulse(1'b1, 8'b0000_0001, 1);
    do_read(1'b1, 3'd0, 3, 1'b0, 1'b0);
    check("b ovf sticky", int'(ovf_b), 1);

    // Asynchronous reset while in ACK
    pulse(1'b0, 8'b0000_1000, 6);
    qa.push_back(6);
    @(negedge clk);
    req_a = 1'b1;
    sel_a = 3'd3;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("ack before reset", int'(ack_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ack cleared by async reset", int'(ack_a), 0);
    check("rd_data cleared by async reset", int'(data_a), 0);
    @(negedge clk);
    req_a = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c += 3) do_read(1'b0, 3'(c), 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard a drained", qa.size(), 0);
    check("scoreboard b drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
